// File: rtl/piano_pkg.sv
// Shared piano definitions: note codes, ROM entry layout, sequencer states
// and the note-to-LED mapping used by every block on the note bus.
package piano_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 2;
  localparam int ENTRY_W = DUR_W + NOTE_W;
  localparam int LED_W   = 8;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_C2   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;
  } rom_entry_t;

  // Codes above C2 have no LED and light nothing.
  function automatic logic [LED_W-1:0] note_to_led(input logic [NOTE_W-1:0] n);
    logic [LED_W-1:0] r;
    r = '0;
    if (n != NOTE_NONE && n <= NOTE_C2)
      r[3'(n - 4'd1)] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Ode to Joy phrase table: index -> {beats, note}. Unused indices play nothing.
module song_rom
  import piano_pkg::*;
(
  input  logic [3:0] idx,
  output rom_entry_t entry
);

  always_comb begin
    entry = '{dur: 2'd0, note: NOTE_NONE};
    case (idx)
      4'd0:  entry = '{dur: 2'd1, note: NOTE_E};
      4'd1:  entry = '{dur: 2'd1, note: NOTE_E};
      4'd2:  entry = '{dur: 2'd1, note: NOTE_F};
      4'd3:  entry = '{dur: 2'd1, note: NOTE_G};
      4'd4:  entry = '{dur: 2'd1, note: NOTE_G};
      4'd5:  entry = '{dur: 2'd1, note: NOTE_F};
      4'd6:  entry = '{dur: 2'd1, note: NOTE_E};
      4'd7:  entry = '{dur: 2'd1, note: NOTE_D};
      4'd8:  entry = '{dur: 2'd1, note: NOTE_C};
      4'd9:  entry = '{dur: 2'd1, note: NOTE_C};
      4'd10: entry = '{dur: 2'd1, note: NOTE_D};
      4'd11: entry = '{dur: 2'd1, note: NOTE_E};
      4'd12: entry = '{dur: 2'd1, note: NOTE_E};
      4'd13: entry = '{dur: 2'd1, note: NOTE_D};
      4'd14: entry = '{dur: 2'd2, note: NOTE_D};
      default: entry = '{dur: 2'd0, note: NOTE_NONE};
    endcase
  end

endmodule

// File: rtl/song_player.sv
// Autoplay sequencer: steps through the song ROM, sounding each note for its
// duration in beats followed by a silent gap, optionally looping.
module song_player
  import piano_pkg::*;
#(
  parameter int BEAT_CYC = 25_000_000,
  parameter int GAP_CYC  = 5_000_000,
  parameter int SONG_LEN = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [3:0] note,
  output logic [7:0] Led,
  output logic       busy,
  output logic       done,
  output logic [3:0] idx
);

  localparam int PLAY_MAX = 2 * BEAT_CYC;
  localparam int CNT_W    = $clog2((PLAY_MAX > GAP_CYC) ? PLAY_MAX : GAP_CYC) + 1;
  localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       dur_reg, dur_next;
  logic [3:0]       idx_reg, idx_next;
  logic [3:0]       note_reg, note_next;
  logic [7:0]       led_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [3:0]       rom_addr;
  rom_entry_t       rom_entry;
  logic [CNT_W-1:0] play_last;

  // The ROM is addressed with the entry about to be loaded, not the one sounding.
  assign rom_addr = (state_reg == ST_GAP && idx_reg != LAST_IDX) ? 4'(idx_reg + 4'd1) : 4'd0;

  song_rom u_rom (
    .idx   (rom_addr),
    .entry (rom_entry)
  );

  assign play_last = CNT_W'(dur_reg) * CNT_W'(BEAT_CYC) - CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dur_next   = dur_reg;
    idx_next   = idx_reg;
    note_next  = note_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      dur_next   = '0;
      idx_next   = '0;
      note_next  = NOTE_NONE;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          note_next = NOTE_NONE;
          if (start) begin
            state_next = ST_PLAY;
            cnt_next   = '0;
            idx_next   = '0;
            note_next  = rom_entry.note;
            dur_next   = rom_entry.dur;
            busy_next  = 1'b1;
          end
        end
        ST_PLAY: begin
          if (cnt_reg == play_last) begin
            state_next = ST_GAP;
            cnt_next   = '0;
            note_next  = NOTE_NONE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_reg == CNT_W'(GAP_CYC - 1)) begin
            cnt_next = '0;
            if (idx_reg != LAST_IDX || loop) begin
              state_next = ST_PLAY;
              idx_next   = rom_addr;
              note_next  = rom_entry.note;
              dur_next   = rom_entry.dur;
            end else begin
              state_next = ST_IDLE;
              idx_next   = '0;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          note_next  = NOTE_NONE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dur_reg   <= '0;
      idx_reg   <= '0;
      note_reg  <= NOTE_NONE;
      led_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dur_reg   <= dur_next;
      idx_reg   <= idx_next;
      note_reg  <= note_next;
      led_reg   <= note_to_led(note_next);
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign note = note_reg;
  assign Led  = led_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign idx  = idx_reg;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with short beats (BEAT=4, GAP=2).
module tb_song_player;

  logic       CLK = 1'b0;
  logic       RESET, start, stop, loop;
  logic [3:0] note, idx;
  logic [7:0] Led;
  logic       busy, done;

  int tests  = 0;
  int failed = 0;

  int         busy_cnt, done_cnt, last_hold, post_idle;
  logic [3:0] seq[$];
  logic [3:0] exp_song [15] = '{4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2,
                                4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2};

  song_player #(.BEAT_CYC(4), .GAP_CYC(2), .SONG_LEN(15)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .stop  (stop),
    .loop  (loop),
    .note  (note),
    .Led   (Led),
    .busy  (busy),
    .done  (done),
    .idx   (idx)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Samples once per cycle until three idle samples have been seen.
  task automatic run_until_idle(input int budget, input logic [3:0] prev0);
    logic [3:0] prev;
    int hold;
    busy_cnt = 0; done_cnt = 0; last_hold = 0; post_idle = 0; hold = 0;
    seq.delete();
    prev = prev0;
    for (int c = 0; c < budget && post_idle < 3; c++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (note != 4'd0) begin
        if (prev == 4'd0) begin
          seq.push_back(note);
          hold = 0;
        end
        hold++;
        last_hold = hold;
      end
      prev = note;
      if (!busy) post_idle++;
      step();
    end
    chk("idle_reached", post_idle, 3);
  endtask

  task automatic wait_idx(input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (idx !== target && n < budget) begin
      step();
      n++;
    end
    chk("wait_idx", idx, target);
  endtask

  initial begin
    int n, dcnt;
    logic seen14;
    RESET = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    #1;
    chk("rst_note", note, 0);
    chk("rst_led", Led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", idx, 0);
    step(); step();
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("idle20_note", note, 0);
    chk("idle20_busy", busy, 0);
    chk("idle20_idx", idx, 0);

    // First note, its gap, and the second note
    pulse_start();
    chk("t2_note", note, 3);
    chk("t2_led", Led, 8'h04);
    chk("t2_busy", busy, 1);
    chk("t2_idx", idx, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t2_note_c4", note, 3);
    step();
    chk("t2_gap1_note", note, 0);
    chk("t2_gap1_led", Led, 0);
    chk("t2_gap1_busy", busy, 1);
    step();
    chk("t2_gap2_note", note, 0);
    step();
    chk("t2_n2_note", note, 3);
    chk("t2_n2_idx", idx, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t2_stop_busy", busy, 0);

    // Complete song without looping
    step();
    pulse_start();
    run_until_idle(200, 4'd0);
    chk("t3_busy_cycles", busy_cnt, 94);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_last_hold", last_hold, 8);
    chk("t3_seq_len", seq.size(), 15);
    for (int i = 0; i < 15; i++)
      if (i < seq.size()) chk($sformatf("t3_seq%0d", i), seq[i], exp_song[i]);
    chk("t3_end_idx", idx, 0);

    // Stop mid-note
    pulse_start();
    wait_idx(4'd5, 60);
    step();
    chk("t4_playing", note, 4);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_note", note, 0);
    chk("t4_led", Led, 0);
    chk("t4_busy", busy, 0);
    chk("t4_idx", idx, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcnt++;
      step();
    end
    chk("t4_no_done", dcnt, 0);
    pulse_start();
    chk("t4_replay_note", note, 3);
    chk("t4_replay_idx", idx, 0);
    stop = 1'b1; step(); stop = 1'b0;

    // Looping playback, then loop cleared on the second pass
    loop = 1'b1;
    pulse_start();
    seen14 = 1'b0; dcnt = 0; n = 0;
    while (!(seen14 && idx == 4'd0) && n < 200) begin
      if (idx == 4'd14) seen14 = 1'b1;
      if (done) dcnt++;
      step();
      n++;
    end
    chk("t5_wrap_seen", seen14, 1);
    chk("t5_wrap_idx", idx, 0);
    chk("t5_wrap_note", note, 3);
    chk("t5_wrap_busy", busy, 1);
    chk("t5_no_done", dcnt, 0);
    loop = 1'b0;
    run_until_idle(200, note);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_seq_len", seq.size(), 14);

    // Start while busy is ignored
    pulse_start();
    wait_idx(4'd7, 60);
    pulse_start();
    chk("t6_ignore_idx", idx, 7);
    chk("t6_ignore_note", note, 2);
    run_until_idle(200, note);
    chk("t6_seq_len", seq.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < seq.size()) chk($sformatf("t6_seq%0d", i), seq[i], exp_song[i+8]);
    chk("t6_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-song
    pulse_start();
    wait_idx(4'd9, 80);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_rst_note", note, 0);
    chk("t6_rst_led", Led, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_idx", idx, 0);
    chk("t6_rst_done", done, 0);
    step();
    RESET = 1'b0;
    step();
    pulse_start();
    chk("t6_restart_note", note, 3);
    chk("t6_restart_busy", busy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
